// File: rtl/icache_fill_fsm_if.sv
// icache_fill_fsm_if: signal bundle between the cache miss path, main memory and the fill engine
// Ports (master = fill engine, slave = cache/memory side):
//   miss_detected, miss_address           cache miss request
//   memory_data_valid, memory_data        in-order memory return
//   fsm_busy                              fetch stall
//   mem_read, memory_address              memory read request
//   write_data_array, fill_word           data array write strobe and word slot
//   write_tag_array, fill_tag, fill_done  tag write and fill completion
//   crit_valid                            first returned word (ICACHE_CRITICAL_WORD_FIRST_EN only)
interface icache_fill_fsm_if #(
    parameter int WORDS = 8
);
    logic                       miss_detected;
    logic [15:0]                miss_address;
    logic                       memory_data_valid;
    logic [15:0]                memory_data;
    logic                       fsm_busy;
    logic                       mem_read;
    logic [15:0]                memory_address;
    logic                       write_data_array;
    logic [$clog2(WORDS)-1:0]   fill_word;
    logic                       write_tag_array;
    logic [15:0]                fill_tag;
    logic                       fill_done;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic                       crit_valid;
`endif

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read, memory_address, write_data_array, fill_word,
               write_tag_array, fill_tag, fill_done
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        , crit_valid
`endif
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read, memory_address, write_data_array, fill_word,
               write_tag_array, fill_tag, fill_done
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        , crit_valid
`endif
    );
endinterface

// File: rtl/icache_fill_fsm.sv
// icache_fill_fsm: instruction cache miss engine that refills one block from pipelined memory
// Ports: clk, rst_n (async active-low), bus (icache_fill_fsm_if.master: miss in, memory
//   request/return, data/tag array write strobes, fsm_busy stall, fill_done pulse).
// Optional macro ICACHE_CRITICAL_WORD_FIRST_EN: start the fill at the missing word, wrap
//   modulo WORDS, and pulse crit_valid with the first data array write.
module icache_fill_fsm #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input logic               clk,
    input logic               rst_n,
    icache_fill_fsm_if.master bus
);
    localparam int W = $clog2(WORDS);
    localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);

    if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_cfg
        $error("icache_fill_fsm: MEM_LAT must be >= 1 and WORDS a power of two >= 2");
    end

    typedef enum logic {IDLE, FILL} state_t;

    state_t         state_q, state_d;
    logic [W:0]     issue_cnt_q, issue_cnt_d;
    logic [W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [15:0]    tag_q, tag_d;
    logic [W-1:0]   issue_word, recv_word;
    logic           issuing, recv, last;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic [W-1:0]   start_q, start_d;
`endif

    always_comb begin
        issuing = state_q == FILL && issue_cnt_q < (W + 1)'(WORDS);
        // a return is only accepted for a word already issued, so early or surplus beats write nothing
        recv = state_q == FILL && bus.memory_data_valid && {1'b0, recv_cnt_q} < issue_cnt_q;
        last = recv && recv_cnt_q == W'(WORDS - 1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        issue_word = issue_cnt_q[W-1:0] + start_q;
        recv_word = recv_cnt_q + start_q;
        start_d = start_q;
`else
        issue_word = issue_cnt_q[W-1:0];
        recv_word = recv_cnt_q;
`endif
        state_d = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d = recv_cnt_q;
        tag_d = tag_q;
        if (state_q == IDLE) begin
            if (bus.miss_detected) begin
                state_d = FILL;
                tag_d = bus.miss_address & BLK_MASK;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                start_d = bus.miss_address[W:1];
`endif
            end
        end else begin
            issue_cnt_d = issue_cnt_q + (W + 1)'(issuing);
            recv_cnt_d = recv_cnt_q + W'(recv);
            if (last) begin
                state_d = IDLE;
                issue_cnt_d = '0;
                recv_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q <= '0;
            tag_q <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q <= recv_cnt_d;
            tag_q <= tag_d;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            start_q <= start_d;
`endif
        end
    end

    assign bus.fsm_busy = state_q == FILL;
    assign bus.mem_read = issuing;
    assign bus.memory_address = issuing ? tag_q + {{(15 - W){1'b0}}, issue_word, 1'b0} : 16'h0;
    assign bus.write_data_array = recv;
    assign bus.fill_word = recv_word;
    assign bus.write_tag_array = last;
    assign bus.fill_tag = tag_q;
    assign bus.fill_done = last;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign bus.crit_valid = recv && recv_cnt_q == '0;
`endif
endmodule

// File: doc/icache_fill_fsm.md
Name: icache_fill_fsm

Overview:
- Miss-handling engine between the instruction cache and the multi-cycle pipelined main memory; it feeds refilled instruction blocks upstream of fetch.
- On a cache miss it latches the block address and issues one memory read per cycle for every word in the block.
- It steers each returned word into the cache data array, writes the tag on the final word, and holds fetch stalled via fsm_busy until the fill completes.

Parameters:
- MEM_LAT, 4, cycles from an address issue to its data-valid return (must be >= 1)
- WORDS, 8, 16-bit words per cache block (power of two; block = 2*WORDS bytes)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- miss_detected  input  1  cache miss this cycle; sampled only in IDLE
- miss_address  input  16  byte address of the missing instruction
- memory_data_valid  input  1  memory returns one word this cycle
- memory_data  input  16  returned word
- fsm_busy  output  1  fill in progress; fetch stalls while high
- mem_read  output  1  read request to memory this cycle
- memory_address  output  16  byte address of the current request; 0 when mem_read is low
- write_data_array  output  1  write memory_data into the data array
- fill_word  output  log2(WORDS)  word index within the block for write_data_array
- write_tag_array  output  1  write fill_tag into the tag array
- fill_tag  output  16  latched block base address (miss_address with the low log2(2*WORDS) bits cleared)
- fill_done  output  1  one-cycle pulse on the final word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; issue and receive counters = 0; fill_tag = 0. All outputs are 0.
- States: IDLE, FILL.
- IDLE -> FILL: at a clk edge where miss_detected = 1. On the same edge, fill_tag <= block base of miss_address.
- In IDLE, memory_data_valid is ignored; stale returns are dropped.
- FILL, issue side:
  - mem_read = 1 while issue_cnt < WORDS.
  - memory_address = fill_tag + 2*issue_cnt.
  - issue_cnt increments every FILL cycle until it reaches WORDS, then mem_read = 0.
  - Issue order is sequential: word 0 .. WORDS-1.
- FILL, receive side:
  - Each memory_data_valid pulses write_data_array = 1 combinationally that cycle.
  - fill_word = recv_cnt, and recv_cnt increments.
  - Memory returns in order; the FSM does not track per-word addresses.
- Final word (valid while recv_cnt = WORDS-1):
  - write_data_array, write_tag_array and fill_done are all 1 in that cycle.
  - Next state is IDLE; counters clear.
- fsm_busy = (state == FILL). It rises the cycle after the miss edge and falls the cycle after fill_done.
- Latency, defaults: miss sampled at edge 0; issues in cycles 1..8; returns in cycles 5..12; fill_done in cycle 12; fsm_busy high for cycles 1..12 (WORDS+MEM_LAT cycles in general).
- miss_detected while in FILL is ignored; the cache re-asserts it after the fill.
- miss_detected in the same cycle as fill_done is ignored. It is re-sampled in IDLE the following cycle.
- memory_data_valid before any issue in FILL, or once recv_cnt has reached WORDS: cannot occur with a conforming memory. The FSM asserts no write for it.
- Address arithmetic: 16-bit, wrap-around modulo 2^16. Block 0xFFF0 issues 0xFFF0..0xFFFE.
- Reset mid-fill: immediately IDLE with all outputs 0; no partial tag write. Any in-flight returns after reset are ignored.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- With the macro defined:
  - Also latch start = miss_address word offset.
  - Issue order is start, start+1, .., wrapping modulo WORDS.
  - fill_word = (start + recv_cnt) mod WORDS.
  - Add output crit_valid (1 bit), pulsed with the first write_data_array of each fill, so fetch can forward the missing word early.
- Without the macro:
  - Sequential order from word 0.
  - The crit_valid port does not exist.

Test Plan:
- Reset -> all outputs 0. Miss at 0x1236 -> fill_tag 0x1230; addresses 0x1230,0x1232..0x123E in cycles 1-8; writes word 0..7 in cycles 5-12; write_tag_array + fill_done in cycle 12 only; fsm_busy cycles 1-12.
- Miss held high through a whole fill, plus a new miss at 0x4000 in the fill_done cycle -> second miss accepted only from the next IDLE cycle; no overlap; fill_tag 0x4000.
- Deassert rst_n in cycle 6 of a fill, release, then drive 3 late memory_data_valid -> no write_data_array or write_tag_array; fsm_busy 0; memory_address 0.
- Miss at 0xFFFA -> fill_tag 0xFFF0; last address 0xFFFE; no carry out.
- Memory model with MEM_LAT=1 and random stalls between misses -> every block lands in the correct word slots; fill_done count equals miss count.
- With ICACHE_CRITICAL_WORD_FIRST_EN, miss at 0x200A -> issue order 0x200A,0x200C,0x200E,0x2000..0x2008; fill_word 5,6,7,0..4; crit_valid with the first write only.
